// File: rtl/combination_sender.sv
// Sends a four-digit combination to a lock with alternating Key1/Key2 strobes,
// waits for the unlock status, and retries a bounded number of times before failing.
module combination_sender #(
  parameter logic [3:0] CODE0     = 4'b1101,
  parameter logic [3:0] CODE1     = 4'b0111,
  parameter logic [3:0] CODE2     = 4'b1001,
  parameter logic [3:0] CODE3     = 4'b0001,
  parameter int         GAP       = 2,
  parameter int         TIMEOUT   = 8,
  parameter int         MAX_RETRY = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Lock,
  output logic       LockReset,
  output logic       Key1,
  output logic       Key2,
  output logic [3:0] Password,
  output logic       Busy,
  output logic       Done,
  output logic       Fail,
  output logic [2:0] Attempt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] STROBE = 3'd3;
  localparam logic [2:0] GAPW   = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] FAIL   = 3'd7;

  localparam logic [7:0] GAP_LAST  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  logic [2:0] state;
  logic [1:0] idx;
  logic [7:0] gcnt;
  logic [7:0] tcnt;
  logic [2:0] attempt;
  logic       gap_end;

  function automatic logic [3:0] digit(input logic [1:0] i);
    case (i)
      2'd0:    digit = CODE0;
      2'd1:    digit = CODE1;
      2'd2:    digit = CODE2;
      default: digit = CODE3;
    endcase
  endfunction

  // With GAP=0 the strobe cycle itself ends the gap, so GAPW is never entered.
  assign gap_end = ((state == STROBE) && (GAP == 0)) ||
                   ((state == GAPW) && (gcnt == GAP_LAST));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= 2'd0;
      gcnt    <= 8'd0;
      tcnt    <= 8'd0;
      attempt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= CLEAR;
            attempt <= 3'd1;
          end
        end
        CLEAR: begin
          idx   <= 2'd0;
          state <= SETUP;
        end
        SETUP: state <= STROBE;
        STROBE, GAPW: begin
          if (gap_end) begin
            if (idx == 2'd3) begin
              tcnt  <= 8'd0;
              state <= WAIT;
            end else begin
              idx   <= idx + 2'd1;
              state <= SETUP;
            end
          end else if (state == STROBE) begin
            gcnt  <= 8'd0;
            state <= GAPW;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        WAIT: begin
          // Unlock wins over timeout when both happen in the last WAIT cycle.
          if (Lock == 4'b1111) begin
            state <= DONE;
          end else if (tcnt == TO_LAST) begin
            if (attempt <= RETRY_MAX) begin
              attempt <= attempt + 3'd1;
              state   <= CLEAR;
            end else begin
              state <= FAIL;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          attempt <= 3'd0;
        end
      endcase
    end
  end

  assign LockReset = (state == CLEAR);
  assign Key1      = (state == STROBE) && !idx[0];
  assign Key2      = (state == STROBE) && idx[0];
  assign Password  = ((state == SETUP) || (state == STROBE)) ? digit(idx) : 4'd0;
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign Fail      = (state == FAIL);
  assign Attempt   = attempt;

endmodule
